player_bullet: RTL and testbench

- Consumes the frame-latched player_x/player_y from the player block.
- Launches a single upward-travelling bullet on a fire press and steps it toward the top of the screen.
- Retires the bullet on a hit pulse from collision logic or on reaching the top, then enforces a per-frame cooldown.
- Publishes bullet position and active flag once per frame for the renderer and collision logic.

---
 rtl/player_bullet_pkg.sv | 38 +++
 rtl/player_bullet_if.sv | 33 +++
 rtl/player_bullet.sv | 137 +++++++++++++
 tb/tb_player_bullet.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/player_bullet_pkg.sv
// -----------------------------------------------------------------------------
// player_bullet_pkg
// Shared game constants and encodings for the player-bullet slice.
//   RES_H / SPRITE_WIDTH_SCALED / PLAYER_STEP : screen and player geometry
//   BULLET_* / TOP_LIMIT / COOLDOWN_FRAMES    : default bullet parameters
//   ST_*                                      : bullet FSM state encodings
//   launch_y()                                : clamped spawn height helper
// -----------------------------------------------------------------------------
package player_bullet_pkg;

    localparam int COORD_W             = 10;
    localparam int RES_H               = 480;
    localparam int SPRITE_WIDTH_SCALED = 32;
    localparam int PLAYER_STEP         = 4;

    localparam int BULLET_STEP     = 4;
    localparam int BULLET_W        = 2;
    localparam int BULLET_H        = 8;
    localparam int TOP_LIMIT       = 0;
    localparam int COOLDOWN_FRAMES = 8;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FLY  = 2'd1;
    localparam logic [1:0] ST_COOL = 2'd2;

    // Spawn the bullet directly above the player, but never above the top
    // limit: a player hugging the top edge would otherwise underflow.
    function automatic coord_t launch_y(input coord_t player_y,
                                        input coord_t top_limit,
                                        input coord_t bullet_h);
        coord_t top_plus_h;
        top_plus_h = top_limit + bullet_h;
        return (player_y < top_plus_h) ? top_limit : coord_t'(player_y - bullet_h);
    endfunction

endpackage

// File: rtl/player_bullet_if.sv
// -----------------------------------------------------------------------------
// player_bullet_if
// Game-side bus of the player bullet.
//   restart, frame, clk_move, fire, hit, player_x/y : game -> bullet
//   bullet_x/y, bullet_active, shot                 : bullet -> game
// master: game/testbench side, slave: player_bullet side.
// -----------------------------------------------------------------------------
interface player_bullet_if;
    import player_bullet_pkg::*;

    logic   restart;
    logic   frame;
    logic   clk_move;
    logic   fire;
    logic   hit;
    coord_t player_x;
    coord_t player_y;
    coord_t bullet_x;
    coord_t bullet_y;
    logic   bullet_active;
    logic   shot;

    modport master (
        output restart, frame, clk_move, fire, hit, player_x, player_y,
        input  bullet_x, bullet_y, bullet_active, shot
    );

    modport slave (
        input  restart, frame, clk_move, fire, hit, player_x, player_y,
        output bullet_x, bullet_y, bullet_active, shot
    );

endinterface

// File: rtl/player_bullet.sv
// -----------------------------------------------------------------------------
// player_bullet
// Single upward-travelling player bullet: launched on a fire press, stepped
// on clk_move, retired on hit or at the top, followed by a frame cooldown.
// Position/active are published only on frame so render and collision see a
// stable value for the whole frame.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : player_bullet_if.slave (restart, frame, clk_move, fire, hit,
//           player_x/y in; bullet_x/y, bullet_active, shot out)
// -----------------------------------------------------------------------------
module player_bullet
    import player_bullet_pkg::*;
#(
    parameter int BULLET_STEP     = player_bullet_pkg::BULLET_STEP,
    parameter int BULLET_W        = player_bullet_pkg::BULLET_W,
    parameter int BULLET_H        = player_bullet_pkg::BULLET_H,
    parameter int TOP_LIMIT       = player_bullet_pkg::TOP_LIMIT,
    parameter int COOLDOWN_FRAMES = player_bullet_pkg::COOLDOWN_FRAMES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    player_bullet_if.slave         bus
);

    localparam coord_t     X_OFFSET      = coord_t'(SPRITE_WIDTH_SCALED/2 - BULLET_W/2);
    localparam coord_t     STEP_C        = coord_t'(BULLET_STEP);
    localparam coord_t     TOP_C         = coord_t'(TOP_LIMIT);
    localparam coord_t     H_C           = coord_t'(BULLET_H);
    localparam coord_t     TOP_PLUS_STEP = coord_t'(TOP_LIMIT + BULLET_STEP);
    localparam logic [3:0] COOL_INIT     = 4'(COOLDOWN_FRAMES);

    logic [1:0] state_q, state_d;
    coord_t     x_int_q, x_int_d;
    coord_t     y_int_q, y_int_d;
    logic [3:0] cool_q,  cool_d;
    logic       shot_q,  shot_d;
    logic       fire_q;
    coord_t     bullet_x_q, bullet_y_q;
    logic       bullet_active_q;
    logic       fire_edge;

    // Only a fresh press counts; holding the button never re-fires.
    assign fire_edge = bus.fire & ~fire_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned -- that is what keeps this block latch-free.
        state_d = state_q;
        x_int_d = x_int_q;
        y_int_d = y_int_q;
        cool_d  = cool_q;
        shot_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire_edge) begin
                    x_int_d = bus.player_x + X_OFFSET;
                    y_int_d = launch_y(bus.player_y, TOP_C, H_C);
                    shot_d  = 1'b1;
                    state_d = ST_FLY;
                end
            end
            ST_FLY: begin
                // A hit wins over movement; the bullet freezes where it struck.
                if (bus.hit) begin
                    state_d = ST_COOL;
                    cool_d  = COOL_INIT;
                end else if (bus.clk_move) begin
                    // Retire before stepping past the top so y never wraps.
                    if (y_int_q < TOP_PLUS_STEP) begin
                        state_d = ST_COOL;
                        cool_d  = COOL_INIT;
                    end else begin
                        y_int_d = y_int_q - STEP_C;
                    end
                end
            end
            ST_COOL: begin
                if (bus.frame) begin
                    if (cool_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cool_d = cool_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments, so the frame latch below
    // samples x/y/state from before this cycle's update even though both
    // happen in the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            x_int_q         <= '0;
            y_int_q         <= '0;
            cool_q          <= '0;
            shot_q          <= 1'b0;
            fire_q          <= 1'b0;
            bullet_x_q      <= '0;
            bullet_y_q      <= '0;
            bullet_active_q <= 1'b0;
        end else if (bus.restart) begin
            state_q         <= ST_IDLE;
            x_int_q         <= '0;
            y_int_q         <= '0;
            cool_q          <= '0;
            shot_q          <= 1'b0;
            fire_q          <= 1'b0;
            bullet_x_q      <= '0;
            bullet_y_q      <= '0;
            bullet_active_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_int_q <= x_int_d;
            y_int_q <= y_int_d;
            cool_q  <= cool_d;
            shot_q  <= shot_d;
            fire_q  <= bus.fire;
            if (bus.frame) begin
                bullet_x_q      <= x_int_q;
                bullet_y_q      <= y_int_q;
                bullet_active_q <= (state_q == ST_FLY);
            end
        end
    end

    assign bus.bullet_x      = bullet_x_q;
    assign bus.bullet_y      = bullet_y_q;
    assign bus.bullet_active = bullet_active_q;
    assign bus.shot          = shot_q;

endmodule

// File: tb/tb_player_bullet.sv
// -----------------------------------------------------------------------------
// tb_player_bullet
// Directed stimulus for player_bullet. A behavioural model tracks the bullet
// as "flying or not" plus "frames left before re-arm"; a compare process
// checks every published output against it on each falling edge, and
// hand-computed literals pin the model at key points.
// -----------------------------------------------------------------------------
module tb_player_bullet;
    import player_bullet_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_bullet_if bus();

    player_bullet dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_fly;        // bullet currently in the air
    int m_wait;       // frames still to pass before a press is accepted
    int m_x, m_y;     // bullet position while in the air
    bit m_fire_prev;
    int m_bx, m_by;
    bit m_ba, m_shot;

    always @(posedge clk or negedge rst_n) begin : model
        bit edge_seen;
        bit n_fly, n_shot;
        int n_wait, n_x, n_y;
        if (!rst_n || bus.restart) begin
            m_fly <= 0; m_wait <= 0; m_x <= 0; m_y <= 0; m_fire_prev <= 0;
            m_bx <= 0; m_by <= 0; m_ba <= 0; m_shot <= 0;
        end else begin
            edge_seen = bus.fire && !m_fire_prev;
            n_fly = m_fly; n_wait = m_wait; n_x = m_x; n_y = m_y; n_shot = 0;
            if (m_fly) begin
                if (bus.hit) begin
                    n_fly = 0; n_wait = COOLDOWN_FRAMES + 1;
                end else if (bus.clk_move) begin
                    if (m_y - BULLET_STEP < TOP_LIMIT) begin
                        n_fly = 0; n_wait = COOLDOWN_FRAMES + 1;
                    end else begin
                        n_y = m_y - BULLET_STEP;
                    end
                end
            end else if (m_wait > 0) begin
                if (bus.frame) n_wait = m_wait - 1;
            end else if (edge_seen) begin
                n_fly  = 1;
                n_x    = (int'(bus.player_x) + SPRITE_WIDTH_SCALED/2 - BULLET_W/2) % 1024;
                n_y    = int'(bus.player_y) - BULLET_H;
                if (n_y < TOP_LIMIT) n_y = TOP_LIMIT;
                n_shot = 1;
            end
            if (bus.frame) begin
                m_bx <= m_x; m_by <= m_y; m_ba <= m_fly;
            end
            m_fly <= n_fly; m_wait <= n_wait; m_x <= n_x; m_y <= n_y;
            m_shot <= n_shot; m_fire_prev <= bus.fire;
        end
    end

    always @(negedge clk) begin
        check("model_bullet_x", 32'(bus.bullet_x), 32'(m_bx));
        check("model_bullet_y", 32'(bus.bullet_y), 32'(m_by));
        check("model_active",   32'(bus.bullet_active), 32'(m_ba));
        check("model_shot",     32'(bus.shot), 32'(m_shot));
    end

    // ---------------- stimulus helpers ----------------
    logic fire_lvl = 1'b0;

    task automatic step(input bit fr = 0, input bit mv = 0, input bit h = 0);
        @(negedge clk);
        bus.frame    = fr;
        bus.clk_move = mv;
        bus.hit      = h;
        bus.fire     = fire_lvl;
    endtask

    task automatic frame_once();
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic moves(input int n);
        repeat (n) step(0, 1, 0);
    endtask

    // Press for one cycle, then release; returns once shot is observable.
    task automatic tap();
        fire_lvl = 1'b1;
        step();
        fire_lvl = 1'b0;
        step();
    endtask

    initial begin
        bus.restart  = 1'b0;
        bus.frame    = 1'b0;
        bus.clk_move = 1'b0;
        bus.fire     = 1'b0;
        bus.hit      = 1'b0;
        bus.player_x = 10'd300;
        bus.player_y = 10'd440;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_x", 32'(bus.bullet_x), 0);
        check("reset_y", 32'(bus.bullet_y), 0);
        check("reset_active", 32'(bus.bullet_active), 0);
        check("reset_shot", 32'(bus.shot), 0);

        // Launch from (300,440): x = 300+16-1, y = 440-8.
        tap();
        check("launch_shot", 32'(bus.shot), 1);
        step();
        check("shot_one_cycle", 32'(bus.shot), 0);
        frame_once();
        check("launch_x", 32'(bus.bullet_x), 315);
        check("launch_y", 32'(bus.bullet_y), 432);
        check("launch_active", 32'(bus.bullet_active), 1);

        // Climb 432/4 = 108 ticks to the top, still alive.
        moves(108);
        frame_once();
        check("top_y", 32'(bus.bullet_y), 0);
        check("top_active", 32'(bus.bullet_active), 1);
        moves(1);
        frame_once();
        check("miss_retired", 32'(bus.bullet_active), 0);

        // That frame was cooldown frame 1; press just before re-arm is dropped.
        repeat (7) frame_once();
        tap();
        check("cooldown_press_dropped", 32'(bus.shot), 0);
        frame_once();
        tap();
        check("rearm_shot", 32'(bus.shot), 1);

        // Hit at y=200 together with a move: y holds.
        frame_once();
        moves(58);
        frame_once();
        check("pre_hit_y", 32'(bus.bullet_y), 200);
        step(0, 1, 1);
        frame_once();
        check("hit_y_held", 32'(bus.bullet_y), 200);
        check("hit_retired", 32'(bus.bullet_active), 0);

        // Hit in idle changes nothing.
        repeat (9) frame_once();
        step(0, 0, 1);
        frame_once();
        check("idle_hit_active", 32'(bus.bullet_active), 0);
        check("idle_hit_y", 32'(bus.bullet_y), 200);

        // Held fire across retirement and cooldown never relaunches.
        fire_lvl = 1'b1;
        step();
        step();
        check("held_launch_shot", 32'(bus.shot), 1);
        frame_once();
        step(0, 0, 1);
        repeat (9) frame_once();
        repeat (3) step();
        check("held_no_relaunch", 32'(bus.shot), 0);
        frame_once();
        check("held_inactive", 32'(bus.bullet_active), 0);
        fire_lvl = 1'b0;
        step();
        tap();
        check("release_press_shot", 32'(bus.shot), 1);
        tap();
        check("fly_press_no_shot", 32'(bus.shot), 0);
        frame_once();
        check("single_bullet_y", 32'(bus.bullet_y), 432);

        // Frame and move together at y=100: latch old y, next frame new y.
        moves(83);
        step(1, 1, 0);
        step();
        check("frame_move_latch", 32'(bus.bullet_y), 100);
        frame_once();
        check("frame_move_next", 32'(bus.bullet_y), 96);

        // Async reset between clock edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_x", 32'(bus.bullet_x), 0);
        check("async_rst_y", 32'(bus.bullet_y), 0);
        check("async_rst_active", 32'(bus.bullet_active), 0);
        check("async_rst_shot", 32'(bus.shot), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tap();
        check("post_reset_shot", 32'(bus.shot), 1);
        frame_once();
        check("post_reset_active", 32'(bus.bullet_active), 1);

        // Synchronous restart mid-flight.
        @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("restart_x", 32'(bus.bullet_x), 0);
        check("restart_y", 32'(bus.bullet_y), 0);
        check("restart_active", 32'(bus.bullet_active), 0);
        tap();
        check("post_restart_shot", 32'(bus.shot), 1);
        frame_once();
        check("post_restart_y", 32'(bus.bullet_y), 432);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
